// File: rtl/llc_lookup_ctrl_pkg.sv
// rtl/llc_lookup_ctrl_pkg.sv - shared types and constants for the LLC lookup controller
package llc_lookup_ctrl_pkg;

  localparam int NUM_WAYS   = 8;
  localparam int SET_BITS   = 9;
  localparam int TAG_BITS   = 20;
  localparam int STATE_BITS = 3;
  localparam int WAY_BITS   = $clog2(NUM_WAYS);

  typedef logic [SET_BITS-1:0]            llc_set_t;
  typedef logic [TAG_BITS-1:0]            llc_tag_t;
  typedef logic [WAY_BITS-1:0]            llc_way_t;
  typedef logic [STATE_BITS-1:0]          llc_state_t;
  typedef logic [SET_BITS+WAY_BITS-1:0]   llc_addr_t;
  typedef logic [NUM_WAYS*TAG_BITS-1:0]   llc_tags_t;
  typedef logic [NUM_WAYS*STATE_BITS-1:0] llc_states_t;

  localparam llc_state_t STATE_INVALID = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_RESP,
    ST_WRITE
  } llc_fsm_t;

endpackage

// File: rtl/llc_lookup_ctrl_if.sv
// rtl/llc_lookup_ctrl_if.sv - lookup/update/response and array buses of the LLC lookup controller
interface llc_lookup_ctrl_if;
  import llc_lookup_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  llc_set_t    req_set;
  llc_tag_t    req_tag;

  logic        upd_valid;
  logic        upd_ready;
  llc_set_t    upd_set;
  llc_way_t    upd_way;
  llc_tag_t    upd_tag;
  llc_state_t  upd_state;
  llc_way_t    upd_evict_way;

  logic        mem_rd_en;
  llc_set_t    mem_rd_set;
  llc_tags_t   mem_rd_tag;
  llc_states_t mem_rd_state;
  llc_way_t    mem_rd_evict_way;

  logic        mem_wr_en;
  llc_addr_t   mem_wr_addr;
  llc_tag_t    mem_wr_tag;
  llc_state_t  mem_wr_state;
  llc_way_t    mem_wr_evict_way;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  llc_way_t    resp_way;
  llc_state_t  resp_state;

  modport slave (
    input  req_valid, req_set, req_tag,
    input  upd_valid, upd_set, upd_way, upd_tag, upd_state, upd_evict_way,
    input  mem_rd_tag, mem_rd_state, mem_rd_evict_way,
    input  resp_ready,
    output req_ready, upd_ready,
    output mem_rd_en, mem_rd_set,
    output mem_wr_en, mem_wr_addr, mem_wr_tag, mem_wr_state, mem_wr_evict_way,
    output resp_valid, resp_hit, resp_way, resp_state
  );

  modport master (
    output req_valid, req_set, req_tag,
    output upd_valid, upd_set, upd_way, upd_tag, upd_state, upd_evict_way,
    output mem_rd_tag, mem_rd_state, mem_rd_evict_way,
    output resp_ready,
    input  req_ready, upd_ready,
    input  mem_rd_en, mem_rd_set,
    input  mem_wr_en, mem_wr_addr, mem_wr_tag, mem_wr_state, mem_wr_evict_way,
    input  resp_valid, resp_hit, resp_way, resp_state
  );

endinterface

// File: rtl/llc_lookup_ctrl_way_select.sv
// rtl/llc_lookup_ctrl_way_select.sv - combinational tag compare with hit / victim way selection
module llc_way_select
  import llc_lookup_ctrl_pkg::*;
(
  input  llc_tags_t   tags_i,
  input  llc_states_t states_i,
  input  llc_tag_t    tag_i,
  input  llc_way_t    evict_way_i,
  output logic        hit_o,
  output llc_way_t    way_o,
  output llc_state_t  state_o
);

  logic     inv_found;
  llc_way_t hit_way;
  llc_way_t inv_way;

  // Scan from the top down so the lowest matching / invalid index is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (states_i[i*STATE_BITS +: STATE_BITS] != STATE_INVALID &&
          tags_i[i*TAG_BITS +: TAG_BITS] == tag_i) begin
        hit_o   = 1'b1;
        hit_way = llc_way_t'(i);
      end
      if (states_i[i*STATE_BITS +: STATE_BITS] == STATE_INVALID) begin
        inv_found = 1'b1;
        inv_way   = llc_way_t'(i);
      end
    end
  end

  always_comb begin
    way_o   = hit_o ? hit_way : (inv_found ? inv_way : evict_way_i);
    state_o = states_i[way_o*STATE_BITS +: STATE_BITS];
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// rtl/llc_lookup_ctrl.sv - sequences set reads and way writes against the LLC local array
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  llc_lookup_ctrl_if.slave bus
);

  llc_fsm_t   state_q;
  logic       req_ready_q;
  logic       upd_ready_q;
  logic       mem_rd_en_q;
  llc_set_t   rd_set_q;
  llc_tag_t   rd_tag_q;
  logic       mem_wr_en_q;
  llc_addr_t  wr_addr_q;
  llc_tag_t   wr_tag_q;
  llc_state_t wr_state_q;
  llc_way_t   wr_evict_q;
  logic       resp_valid_q;
  logic       resp_hit_q;
  llc_way_t   resp_way_q;
  llc_state_t resp_state_q;

  logic       sel_hit;
  llc_way_t   sel_way;
  llc_state_t sel_state;

  // Array data is only meaningful during CAPTURE; the result is registered there.
  llc_way_select u_way_select (
    .tags_i      (bus.mem_rd_tag),
    .states_i    (bus.mem_rd_state),
    .tag_i       (rd_tag_q),
    .evict_way_i (bus.mem_rd_evict_way),
    .hit_o       (sel_hit),
    .way_o       (sel_way),
    .state_o     (sel_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      upd_ready_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
      rd_set_q     <= '0;
      rd_tag_q     <= '0;
      mem_wr_en_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_tag_q     <= '0;
      wr_state_q   <= '0;
      wr_evict_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_state_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Updates win a tie; the lookup stays pending and is taken on the next IDLE cycle.
          if (bus.upd_valid) begin
            wr_addr_q   <= {bus.upd_set, bus.upd_way};
            wr_tag_q    <= bus.upd_tag;
            wr_state_q  <= bus.upd_state;
            wr_evict_q  <= bus.upd_evict_way;
            mem_wr_en_q <= 1'b1;
            req_ready_q <= 1'b0;
            upd_ready_q <= 1'b0;
            state_q     <= ST_WRITE;
          end else if (bus.req_valid) begin
            rd_set_q    <= bus.req_set;
            rd_tag_q    <= bus.req_tag;
            mem_rd_en_q <= 1'b1;
            req_ready_q <= 1'b0;
            upd_ready_q <= 1'b0;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          resp_hit_q   <= sel_hit;
          resp_way_q   <= sel_way;
          resp_state_q <= sel_state;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            upd_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          mem_wr_en_q <= 1'b0;
          req_ready_q <= 1'b1;
          upd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_rd_en_q  <= 1'b0;
          mem_wr_en_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          upd_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.upd_ready        = upd_ready_q;
  assign bus.mem_rd_en        = mem_rd_en_q;
  assign bus.mem_rd_set       = rd_set_q;
  assign bus.mem_wr_en        = mem_wr_en_q;
  assign bus.mem_wr_addr      = wr_addr_q;
  assign bus.mem_wr_tag       = wr_tag_q;
  assign bus.mem_wr_state     = wr_state_q;
  assign bus.mem_wr_evict_way = wr_evict_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_hit         = resp_hit_q;
  assign bus.resp_way         = resp_way_q;
  assign bus.resp_state       = resp_state_q;

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// tb/tb_llc_lookup_ctrl.sv - directed self-checking bench for llc_lookup_ctrl
module tb_llc_lookup_ctrl;
  import llc_lookup_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;

  llc_tag_t   mt [NUM_WAYS];
  llc_state_t ms [NUM_WAYS];

  llc_lookup_ctrl_if bus ();

  llc_lookup_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic load_mem(input llc_way_t evict);
    for (int i = 0; i < NUM_WAYS; i++) begin
      bus.mem_rd_tag[i*TAG_BITS +: TAG_BITS]       = mt[i];
      bus.mem_rd_state[i*STATE_BITS +: STATE_BITS] = ms[i];
    end
    bus.mem_rd_evict_way = evict;
  endtask

  task automatic fill(input llc_tag_t base, input llc_state_t st);
    for (int i = 0; i < NUM_WAYS; i++) begin
      mt[i] = base + llc_tag_t'(i);
      ms[i] = st;
    end
  endtask

  // Accept one lookup and wait (bounded) for resp_valid; lat counts edges from accept.
  task automatic lookup(input llc_set_t s, input llc_tag_t t, output int l);
    bus.req_valid = 1'b1;
    bus.req_set   = s;
    bus.req_tag   = t;
    tick();
    bus.req_valid = 1'b0;
    l = 1;
    while (!bus.resp_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_set       = '0;
    bus.req_tag       = '0;
    bus.upd_valid     = 1'b0;
    bus.upd_set       = '0;
    bus.upd_way       = '0;
    bus.upd_tag       = '0;
    bus.upd_state     = '0;
    bus.upd_evict_way = '0;
    bus.resp_ready    = 1'b1;
    fill(20'h00000, 3'd0);
    load_mem(3'd0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_upd_ready",  32'(bus.upd_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_rd_en",  32'(bus.mem_rd_en),  32'd0);
    chk("rst_mem_wr_en",  32'(bus.mem_wr_en),  32'd0);
    chk("rst_wr_addr",    32'(bus.mem_wr_addr), 32'd0);

    // Hit on way 3; way 5 carries the same tag but is INVALID and must not match.
    fill(20'h01000, 3'd1);
    mt[3] = 20'hABCDE; ms[3] = 3'd2;
    mt[5] = 20'hABCDE; ms[5] = 3'd0;
    load_mem(3'd6);
    bus.req_valid = 1'b1;
    bus.req_set   = 9'd5;
    bus.req_tag   = 20'hABCDE;
    tick();
    bus.req_valid = 1'b0;
    chk("hit_rd_en",     32'(bus.mem_rd_en),  32'd1);
    chk("hit_rd_set",    32'(bus.mem_rd_set), 32'd5);
    chk("hit_req_ready", 32'(bus.req_ready),  32'd0);
    chk("hit_upd_ready", 32'(bus.upd_ready),  32'd0);
    tick();
    chk("hit_rd_en_one", 32'(bus.mem_rd_en),  32'd0);
    chk("hit_early_vld", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("hit_resp_hit",   32'(bus.resp_hit),   32'd1);
    chk("hit_resp_way",   32'(bus.resp_way),   32'd3);
    chk("hit_resp_state", 32'(bus.resp_state), 32'd2);
    tick();
    chk("hit_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("hit_done_ready", 32'(bus.req_ready),  32'd1);

    // Miss with invalid ways 2 and 6: lowest invalid is the victim.
    fill(20'h00100, 3'd3);
    ms[2] = 3'd0; ms[6] = 3'd0;
    load_mem(3'd7);
    lookup(9'd17, 20'h55555, lat);
    chk("inv_latency", 32'(lat),            32'd3);
    chk("inv_hit",     32'(bus.resp_hit),   32'd0);
    chk("inv_way",     32'(bus.resp_way),   32'd2);
    chk("inv_state",   32'(bus.resp_state), 32'd0);
    tick();

    // Full-set miss: victim comes from the eviction pointer.
    fill(20'h00200, 3'd1);
    ms[5] = 3'd4;
    load_mem(3'd5);
    lookup(9'd300, 20'h77777, lat);
    chk("full_latency", 32'(lat),            32'd3);
    chk("full_hit",     32'(bus.resp_hit),   32'd0);
    chk("full_way",     32'(bus.resp_way),   32'd5);
    chk("full_state",   32'(bus.resp_state), 32'd4);
    tick();

    // Simultaneous lookup and update: update wins, lookup taken on the next IDLE cycle.
    fill(20'h00300, 3'd1);
    mt[0] = 20'h0BEEF; ms[0] = 3'd7;
    load_mem(3'd1);
    bus.req_valid     = 1'b1;
    bus.req_set       = 9'd9;
    bus.req_tag       = 20'h0BEEF;
    bus.upd_valid     = 1'b1;
    bus.upd_set       = 9'd7;
    bus.upd_way       = 3'd1;
    bus.upd_tag       = 20'h12345;
    bus.upd_state     = 3'd6;
    bus.upd_evict_way = 3'd3;
    tick();
    bus.upd_valid = 1'b0;
    chk("upd_wr_en",     32'(bus.mem_wr_en),        32'd1);
    chk("upd_wr_addr",   32'(bus.mem_wr_addr),      32'd57);
    chk("upd_wr_tag",    32'(bus.mem_wr_tag),       32'h12345);
    chk("upd_wr_state",  32'(bus.mem_wr_state),     32'd6);
    chk("upd_wr_evict",  32'(bus.mem_wr_evict_way), 32'd3);
    chk("upd_no_rd",     32'(bus.mem_rd_en),        32'd0);
    chk("upd_req_ready", 32'(bus.req_ready),        32'd0);
    tick();
    chk("upd_wr_en_one", 32'(bus.mem_wr_en),        32'd0);
    chk("upd_idle_rdy",  32'(bus.req_ready),        32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("upd_then_rd",   32'(bus.mem_rd_en),        32'd1);
    chk("upd_then_set",  32'(bus.mem_rd_set),       32'd9);
    tick();
    tick();
    chk("upd_rd_valid",  32'(bus.resp_valid),       32'd1);
    chk("upd_rd_hit",    32'(bus.resp_hit),         32'd1);
    chk("upd_rd_way",    32'(bus.resp_way),         32'd0);
    chk("upd_rd_state",  32'(bus.resp_state),       32'd7);
    tick();

    // Backpressure: hit on way 7 held for 10 cycles while the array contents change.
    bus.resp_ready = 1'b0;
    fill(20'h00400, 3'd1);
    mt[7] = 20'hFFFFF; ms[7] = 3'd5;
    load_mem(3'd2);
    lookup(9'd511, 20'hFFFFF, lat);
    chk("bp_latency", 32'(lat), 32'd3);
    fill(20'hFFFFF, 3'd0);
    load_mem(3'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",     32'(bus.resp_valid), 32'd1);
      chk("bp_hit",       32'(bus.resp_hit),   32'd1);
      chk("bp_way",       32'(bus.resp_way),   32'd7);
      chk("bp_state",     32'(bus.resp_state), 32'd5);
      chk("bp_req_ready", 32'(bus.req_ready),  32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    chk("bp_still_valid", 32'(bus.resp_valid), 32'd1);
    tick();
    chk("bp_accepted",    32'(bus.resp_valid), 32'd0);
    chk("bp_ready_back",  32'(bus.req_ready),  32'd1);

    // Reset while in CAPTURE drops the lookup.
    fill(20'h00500, 3'd2);
    load_mem(3'd0);
    bus.req_valid = 1'b1;
    bus.req_set   = 9'd44;
    bus.req_tag   = 20'h00503;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstcap_valid",     32'(bus.resp_valid), 32'd0);
    chk("rstcap_req_ready", 32'(bus.req_ready),  32'd1);
    chk("rstcap_upd_ready", 32'(bus.upd_ready),  32'd1);
    chk("rstcap_wr_en",     32'(bus.mem_wr_en),  32'd0);
    chk("rstcap_rd_en",     32'(bus.mem_rd_en),  32'd0);
    tick();
    chk("rstcap_idle_vld",  32'(bus.resp_valid), 32'd0);

    // Reset while in WRITE kills the write pulse on the following cycle.
    bus.upd_valid = 1'b1;
    bus.upd_set   = 9'd3;
    bus.upd_way   = 3'd6;
    tick();
    bus.upd_valid = 1'b0;
    chk("rstwr_wr_en", 32'(bus.mem_wr_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwr_wr_off", 32'(bus.mem_wr_en), 32'd0);
    chk("rstwr_ready",  32'(bus.upd_ready), 32'd1);

    // Two valid matches: lowest index wins.
    fill(20'h00600, 3'd1);
    mt[4] = 20'h3C3C3; ms[4] = 3'd3;
    mt[6] = 20'h3C3C3; ms[6] = 3'd2;
    load_mem(3'd0);
    lookup(9'd100, 20'h3C3C3, lat);
    chk("dup_latency", 32'(lat),            32'd3);
    chk("dup_hit",     32'(bus.resp_hit),   32'd1);
    chk("dup_way",     32'(bus.resp_way),   32'd4);
    chk("dup_state",   32'(bus.resp_state), 32'd3);
    tick();
    chk("dup_done", 32'(bus.resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/llc_lookup_ctrl.md
Name: llc_lookup_ctrl

Overview:
- Initiator side of the LLC local memory: sequences set reads and way writes against the BRAM array on behalf of the LLC controller.
- Issues a read for a set and captures all ways one cycle later, then performs tag compare and hit/victim selection.
- Returns a single lookup response and serialises write-back updates into the array.
- Sits between the LLC request FSM and the local memory block.

Parameters:
- NUM_WAYS, 8, ways per set (power of two, 2..16).
- SET_BITS, 9, set index width.
- TAG_BITS, 20, tag width.
- STATE_BITS, 3, per-line state width; value 0 = INVALID.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept lookup
- req_set  in  SET_BITS  set to look up
- req_tag  in  TAG_BITS  tag to match
- upd_valid  in  1  update request valid
- upd_ready  out  1  controller can accept update
- upd_set  in  SET_BITS  set to write
- upd_way  in  log2(NUM_WAYS)  way to write
- upd_tag  in  TAG_BITS  new tag
- upd_state  in  STATE_BITS  new state
- upd_evict_way  in  log2(NUM_WAYS)  new per-set eviction pointer
- mem_rd_en  out  1  array read enable
- mem_rd_set  out  SET_BITS  array read set
- mem_rd_tag  in  NUM_WAYS*TAG_BITS  per-way tags, valid the cycle after mem_rd_en
- mem_rd_state  in  NUM_WAYS*STATE_BITS  per-way states, same timing
- mem_rd_evict_way  in  log2(NUM_WAYS)  set eviction pointer, same timing
- mem_wr_en  out  1  array write enable
- mem_wr_addr  out  SET_BITS+log2(NUM_WAYS)  {set, way}
- mem_wr_tag  out  TAG_BITS  write tag
- mem_wr_state  out  STATE_BITS  write state
- mem_wr_evict_way  out  log2(NUM_WAYS)  write eviction pointer
- resp_valid  out  1  lookup response valid
- resp_ready  in  1  consumer accepts response
- resp_hit  out  1  tag matched a non-INVALID way
- resp_way  out  log2(NUM_WAYS)  hit way, else victim way
- resp_state  out  STATE_BITS  state of resp_way

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: FSM = IDLE; all outputs 0 except req_ready = 1 and upd_ready = 1.
- FSM states: IDLE, READ, CAPTURE, RESP, WRITE.
- IDLE
  - req_ready = upd_ready = 1.
  - On upd_valid: latch the update fields and go to WRITE. An update has priority if both valid arrive in the same cycle; the lookup is not accepted that cycle.
  - Else on req_valid: latch set and tag, go to READ.
- READ
  - mem_rd_en = 1 and mem_rd_set = latched set for exactly one cycle, then CAPTURE.
- CAPTURE
  - Register the mem_rd_* buses.
  - Hit = any way with state != 0 and tag == latched tag; the lowest such index wins.
  - On miss, victim = lowest-index way with state == 0; if no way is invalid, victim = mem_rd_evict_way.
  - Go to RESP.
- RESP
  - resp_valid = 1; resp fields are held stable until resp_valid && resp_ready, then go to IDLE.
  - resp_valid is never deasserted before acceptance.
- WRITE
  - mem_wr_en = 1 for exactly one cycle with the latched fields, then IDLE.
- req_ready and upd_ready are 0 in every state except IDLE.
- Latency: request accept to resp_valid = 3 cycles (READ, CAPTURE, RESP entry). Minimum lookup throughput is one per 4 cycles with resp_ready held high.
- mem_rd_en and mem_wr_en are never asserted in the same cycle.
- Reset mid-operation returns to IDLE next edge; any in-flight response or write is dropped, and mem_wr_en is 0 on the cycle after rst.
- Widths: way indices are unsigned; mem_wr_addr = {upd_set, upd_way}.

Decomposition:
- Shared package: llc_set_t, llc_tag_t, llc_way_t, llc_state_t, llc_addr_t, the INVALID state constant, and NUM_WAYS.
- One sub-module: llc_way_select. It is combinational and takes tags, states, the latched tag and the eviction pointer, and returns hit, way and state. It is reused by the eviction logic.

Test Plan:
- Lookup hit: set 5, tag 0xABCDE, array way 3 state 2 with matching tag -> resp_hit=1, resp_way=3, resp_state=2; resp_valid 3 cycles after accept.
- Miss with invalid ways: ways 2 and 6 state 0, no match -> resp_hit=0, resp_way=2.
- Full-set miss: all ways valid, none match, mem_rd_evict_way=5 -> resp_hit=0, resp_way=5.
- Simultaneous req_valid and upd_valid (set 7, way 1) -> mem_wr_en one cycle with mem_wr_addr={7,1}; the lookup is accepted on the following IDLE cycle.
- Backpressure: resp_ready low 10 cycles -> resp fields stable, req_ready=0 throughout; accepted on the first ready cycle.
- Reset asserted in CAPTURE -> next cycle IDLE, resp_valid=0, req_ready=1, no mem_wr_en pulse.
